systolic_feeder: RTL
====================

Name: systolic_feeder

Overview:
Input staging block directly upstream of the TPU processing-element array. It accepts a KxK weight matrix and a stream of K-element activation vectors over valid/ready handshakes. It sequences the array's weight-load phase, then streams buffered activations with a diagonal skew, delaying row i by i cycles, so that values arrive at the systolic grid correctly aligned. It signals batch completion after the skew pipeline drains.

Parameters:
K, 2, array dimension (rows = columns = K); supported range 2..8
DW, 8, element width in bits
DEPTH, 4, activation FIFO depth in vectors; power of two, >= 2

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
w_valid  in  1  weight matrix valid
w_ready  out  1  weight matrix accepted when w_valid && w_ready
w_data  in  K*K*DW  element (r,c) at bits [(r*K+c)*DW +: DW]
in_valid  in  1  activation vector valid
in_ready  out  1  activation vector accepted when in_valid && in_ready
in_data  in  K*DW  element i at bits [i*DW +: DW]
in_last  in  1  marks the final vector of a batch; travels with the vector
pe_load_weights  out  1  array weight-shift enable
pe_weights  out  K*DW  weight row presented to the top of the array, column c at [c*DW +: DW]
pe_valid  out  K  per-row activation valid
pe_data  out  K*DW  per-row activation, row i at [i*DW +: DW]
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse when the batch has fully left the skew pipe

Behaviour:
- Reset, synchronous: state=IDLE, FIFO emptied, weight register and skew registers cleared. All outputs 0 except in_ready=1. w_ready=1 from the first cycle after reset.
- All outputs are registered except w_ready and in_ready. w_ready = (state==IDLE). in_ready = (fifo_count != DEPTH).
- FIFO:
  - Stores {in_last, in_data}. Push occurs on in_valid && in_ready, in any state.
  - Pop occurs only in STREAM and only when non-empty.
  - Push and pop in the same cycle leave the count unchanged. When full, in_ready=0, so there is no push even if a pop occurs that cycle.
  - Pointers wrap modulo DEPTH.
- FSM:
  - IDLE: on w_valid && w_ready, capture w_data and load cnt=0, then go to LOAD_W.
  - LOAD_W: lasts exactly K cycles. Each cycle drives pe_load_weights=1 and pe_weights=row (K-1-cnt), so the bottom row goes out first and row 0 last, then increments cnt. After the cycle with cnt=K-1, go to STREAM. pe_valid=0 throughout.
  - STREAM: each cycle with the FIFO non-empty, pop one vector into the skew stage. An empty FIFO inserts a bubble, with valid 0 for that column slot. When the popped entry has last=1, load cnt=0 and go to DRAIN in the next cycle. No further pops occur until the next batch.
  - DRAIN: lasts K cycles, with no pops and zero injected into skew stage 0. On the final DRAIN cycle, done=1 for exactly that cycle, then go to IDLE.
- Skew timing:
  - A vector popped at edge t drives pe_data[0]/pe_valid[0] from t+1.
  - Row i is driven from t+1+i through an i-deep register chain carrying data and valid.
  - After the last vector's pop, row K-1 presents its data in the last DRAIN cycle, the same cycle done=1.
- Data is passed unmodified; no arithmetic. pe_data of an invalid row is 0.
- Vectors pushed after in_last, or during LOAD_W/DRAIN/IDLE, stay in the FIFO and are consumed by the next batch's STREAM phase.
- w_valid outside IDLE is ignored (w_ready=0). in_last on a vector pushed into an empty FIFO behaves identically to any other case.
- rst asserted mid-operation aborts immediately: FIFO contents are discarded, no done pulse, and the block returns to IDLE the following cycle.

Test Plan:
1. Reset, then idle 3 cycles -> w_ready=1, in_ready=1, busy=0, pe_valid=00, done=0.
2. K=2, w_data={(0,0)=1,(0,1)=2,(1,0)=3,(1,1)=4} -> pe_load_weights=1 for exactly 2 cycles: pe_weights={3,4} first, then {1,2}; STREAM follows.
3. Pre-load FIFO with vectors {10,20},{11,21 last}, then load weights -> from STREAM entry: row0 = 10,11 on consecutive cycles; row1 = 20,21 one cycle later; done pulses once, in the same cycle row1=21; busy drops the next cycle.
4. Push 5 vectors with no weights loaded -> in_ready=0 after the 4th accept; the 5th is held. After weights load, the first pop raises in_ready and the 5th is accepted. Order is preserved.
5. STREAM with the FIFO empty for 2 cycles between vectors {1,2} and {3,4 last} -> two bubble slots with pe_valid=0 on each row, skewed by row; done timing is unaffected relative to the last pop.
6. Assert rst during STREAM with 2 vectors queued -> next cycle state=IDLE, pe_valid=00, done never pulses; a fresh batch after reset streams only newly pushed data.

Source files
------------

// File: rtl/systolic_feeder_if.sv
// Handshake and array-side signal bundle for systolic_feeder.
// The feeder takes the slave modport. The upstream source and the PE array take the master modport.
interface systolic_feeder_if #(
    parameter int K  = 2,
    parameter int DW = 8
);
    logic              w_valid;
    logic              w_ready;
    logic [K*K*DW-1:0] w_data;
    logic              in_valid;
    logic              in_ready;
    logic [K*DW-1:0]   in_data;
    logic              in_last;
    logic              pe_load_weights;
    logic [K*DW-1:0]   pe_weights;
    logic [K-1:0]      pe_valid;
    logic [K*DW-1:0]   pe_data;
    logic              busy;
    logic              done;

    // valid/ready: a transfer happens on a rising edge where both are high.
    // The source holds its data stable while valid is high and ready is low.
    modport slave (
        input  w_valid, w_data, in_valid, in_data, in_last,
        output w_ready, in_ready, pe_load_weights, pe_weights, pe_valid, pe_data, busy, done
    );

    modport master (
        output w_valid, w_data, in_valid, in_data, in_last,
        input  w_ready, in_ready, pe_load_weights, pe_weights, pe_valid, pe_data, busy, done
    );
endinterface

// File: rtl/systolic_feeder.sv
// Stages weights and activations for a KxK systolic array.
// Weight rows are shifted in bottom-first, then buffered vectors are streamed with row i delayed by i cycles.
module systolic_feeder #(
    parameter int K     = 2,
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    output logic [1:0]   o_state,
    systolic_feeder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(K + 1);
    localparam int FW = K*DW + 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOAD_W = 2'd1;
    localparam logic [1:0] STREAM = 2'd2;
    localparam logic [1:0] DRAIN  = 2'd3;

    logic [1:0]        r_state;
    logic [CW-1:0]     r_cnt;
    logic [K*K*DW-1:0] r_w;
    logic              r_load;
    logic [K*DW-1:0]   r_pe_w;
    logic              r_busy;
    logic              r_done;

    logic [FW-1:0]     r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;

    logic              w_in_ready;
    logic              w_push;
    logic              w_pop;
    logic [FW-1:0]     w_head;
    logic [CW-1:0]     w_row_sel;
    logic [K*DW-1:0]   w_next_row;

    assign w_in_ready = (r_count != (AW+1)'(DEPTH));
    assign w_push     = bus.in_valid && w_in_ready;
    assign w_pop      = (r_state == STREAM) && (r_count != '0);
    assign w_head     = r_mem[r_rd_ptr];
    assign w_row_sel  = CW'(K-2) - r_cnt;

    always_comb begin
        w_next_row = '0;
        for (int r = 0; r < K; r++) begin
            if (w_row_sel == CW'(r)) w_next_row = r_w[r*K*DW +: K*DW];
        end
    end

    // A full FIFO blocks the push even when a pop happens in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {bus.in_last, bus.in_data};
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_w     <= '0;
            r_load  <= 1'b0;
            r_pe_w  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.w_valid) begin
                        r_w     <= bus.w_data;
                        r_cnt   <= '0;
                        r_load  <= 1'b1;
                        r_pe_w  <= bus.w_data[(K-1)*K*DW +: K*DW];
                        r_busy  <= 1'b1;
                        r_state <= LOAD_W;
                    end
                end
                LOAD_W: begin
                    // The output registers already hold row K-1-cnt; stage the next row up.
                    if (r_cnt == CW'(K-1)) begin
                        r_load  <= 1'b0;
                        r_pe_w  <= '0;
                        r_state <= STREAM;
                    end else begin
                        r_cnt  <= r_cnt + 1'b1;
                        r_pe_w <= w_next_row;
                    end
                end
                STREAM: begin
                    if (w_pop && w_head[FW-1]) begin
                        r_cnt   <= '0;
                        r_state <= DRAIN;
                    end
                end
                default: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(K-2)) r_done <= 1'b1;
                    if (r_cnt == CW'(K-1)) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

    // Row i passes through i+1 registers, so a vector popped at edge t reaches row i after edge t+i.
    for (genvar gi = 0; gi < K; gi++) begin : g_row
        logic [DW-1:0] r_sd [gi+1];
        logic [gi:0]   r_sv;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_sv <= '0;
                for (int j = 0; j <= gi; j++) r_sd[j] <= '0;
            end else begin
                r_sv[0] <= w_pop;
                r_sd[0] <= w_pop ? w_head[gi*DW +: DW] : '0;
                for (int j = 1; j <= gi; j++) begin
                    r_sv[j] <= r_sv[j-1];
                    r_sd[j] <= r_sd[j-1];
                end
            end
        end

        assign bus.pe_valid[gi]           = r_sv[gi];
        assign bus.pe_data[gi*DW +: DW]   = r_sd[gi];
    end

    assign bus.w_ready         = (r_state == IDLE);
    assign bus.in_ready        = w_in_ready;
    assign bus.pe_load_weights = r_load;
    assign bus.pe_weights      = r_pe_w;
    assign bus.busy            = r_busy;
    assign bus.done            = r_done;
    assign o_state             = r_state;
endmodule
